// File: rtl/arm_data_mem_responder_pkg.sv
// Purpose : memory map and TXSTAT field layout for the ARM data-port responder.
// Latency : n/a (constants, types and a combinational address decoder only).
// Backpr. : n/a.
// Contents: address constants, TXSTAT bit indices, decode select enum and decode().
package arm_mem_map_pkg;

  localparam logic [31:0] GPIO_ADDR    = 32'hFFFF_FF00;
  localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_FF04;
  localparam logic [31:0] TXDATA_ADDR  = 32'hFFFF_FF08;
  localparam logic [31:0] TXSTAT_ADDR  = 32'hFFFF_FF0C;
  localparam int          MMIO_SEL_BIT = 31;

  // TXSTAT field positions
  localparam int EMPTY   = 0;
  localparam int FULL    = 1;
  localparam int OVF     = 2;
  localparam int CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_GPIO,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_TXSTAT,
    SEL_NONE
  } sel_e;

  // Byte-offset bits [1:0] never take part in the match.
  function automatic sel_e decode(input logic [31:0] a);
    if (!a[MMIO_SEL_BIT])              return SEL_RAM;
    if (a[31:2] == GPIO_ADDR[31:2])    return SEL_GPIO;
    if (a[31:2] == CYCLE_ADDR[31:2])   return SEL_CYCLE;
    if (a[31:2] == TXDATA_ADDR[31:2])  return SEL_TXDATA;
    if (a[31:2] == TXSTAT_ADDR[31:2])  return SEL_TXSTAT;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/arm_data_mem_responder_if.sv
// Purpose : core data-port bus plus TX byte stream, seen from the responder.
// Latency : n/a (wiring only).
// Backpr. : o_Tx_Valid/i_Tx_Ready handshake on the TX stream; data port has none.
// Ports   : slave = responder side, master = core/consumer side.
interface arm_data_mem_responder_if;
  logic [31:0] i_Data_Address;
  logic        i_Mem_Write;
  logic [31:0] i_Write_Data;
  logic [31:0] o_Read_Data;
  logic [31:0] o_GPIO;
  logic [7:0]  o_Tx_Data;
  logic        o_Tx_Valid;
  logic        i_Tx_Ready;

  modport slave (
    input  i_Data_Address, i_Mem_Write, i_Write_Data, i_Tx_Ready,
    output o_Read_Data, o_GPIO, o_Tx_Data, o_Tx_Valid
  );

  modport master (
    output i_Data_Address, i_Mem_Write, i_Write_Data, i_Tx_Ready,
    input  o_Read_Data, o_GPIO, o_Tx_Data, o_Tx_Valid
  );
endinterface

// File: rtl/arm_data_mem_responder_tx_fifo.sv
// Purpose : TxDepth x 8-bit synchronous FIFO with occupancy count.
// Latency : push visible at the head the cycle after its commit edge (no bypass).
// Backpr. : push while full is refused unless a pop happens in the same cycle.
// Ports   : i_CLK, i_RESET (sync, active high), i_Push/i_Push_Data, i_Pop,
//           o_Head, o_Full, o_Empty, o_Count.
module arm_tx_fifo #(
  parameter int TxDepth = 8
) (
  input  logic                     i_CLK,
  input  logic                     i_RESET,
  input  logic                     i_Push,
  input  logic [7:0]               i_Push_Data,
  input  logic                     i_Pop,
  output logic [7:0]               o_Head,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(TxDepth):0] o_Count
);

  localparam int Aw   = $clog2(TxDepth);
  localparam int CntW = Aw + 1;

  logic [7:0]      r_mem [TxDepth];
  logic [Aw-1:0]   r_wr_ptr;
  logic [Aw-1:0]   r_rd_ptr;
  logic [CntW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == CntW'(TxDepth));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_Pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = i_Push & (~w_full | w_pop_ok);

  always_ff @(posedge i_CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_Push_Data;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are power-of-two wide, so they wrap modulo TxDepth naturally.
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + Aw'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + Aw'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Head  = r_mem[r_rd_ptr];
  assign o_Full  = w_full;
  assign o_Empty = w_empty;
  assign o_Count = r_count;

endmodule

// File: rtl/arm_data_mem_responder.sv
// Purpose : data-port responder: word RAM plus GPIO / CYCLE / TX FIFO MMIO window.
// Latency : loads combinational (0 cycles); stores commit on the next rising edge.
// Backpr. : none on the data port; TX stream drains via o_Tx_Valid/i_Tx_Ready.
// Ports   : i_CLK, i_RESET (sync, active high), bus (slave modport of the data/TX bus).
module arm_data_mem_responder
  import arm_mem_map_pkg::*;
#(
  parameter int BusWidth = 32,  // only 32 is supported
  parameter int RamWords = 64,
  parameter int TxDepth  = 8
) (
  input logic                     i_CLK,
  input logic                     i_RESET,
  arm_data_mem_responder_if.slave bus
);

  localparam int RamAw = $clog2(RamWords);
  localparam int CntW  = $clog2(TxDepth) + 1;

  logic [BusWidth-1:0] r_ram [RamWords];
  logic [BusWidth-1:0] r_gpio;
  logic [BusWidth-1:0] r_cycle;
  logic                r_ovf;

  logic [31:0]         w_addr;
  sel_e                w_sel;
  logic [RamAw-1:0]    w_ram_idx;
  logic                w_wr;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CntW-1:0]     w_count;
  logic [7:0]          w_head;
  logic                w_ovf_set;
  logic [BusWidth-1:0] w_txstat;
  logic [BusWidth-1:0] w_rdata;
  logic                w_unused_ok;

  assign w_addr      = bus.i_Data_Address;
  assign w_sel       = decode(w_addr);
  // Upper RAM-space bits are dropped, so the RAM aliases across addr[30:RamAw+2].
  assign w_ram_idx   = w_addr[RamAw+1:2];
  assign w_unused_ok = ^w_addr[1:0];

  // Reset blocks every store, RAM included.
  assign w_wr   = bus.i_Mem_Write & ~i_RESET;
  assign w_push = w_wr & (w_sel == SEL_TXDATA);
  assign w_pop  = ~w_empty & bus.i_Tx_Ready;
  // A push into a full FIFO is only lost when no pop frees a slot.
  assign w_ovf_set = w_push & w_full & ~w_pop;

  arm_tx_fifo #(.TxDepth(TxDepth)) u_tx_fifo (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_Push      (w_push),
    .i_Push_Data (bus.i_Write_Data[7:0]),
    .i_Pop       (w_pop),
    .o_Head      (w_head),
    .o_Full      (w_full),
    .o_Empty     (w_empty),
    .o_Count     (w_count)
  );

  always_ff @(posedge i_CLK) begin
    if (w_wr && (w_sel == SEL_RAM)) r_ram[w_ram_idx] <= bus.i_Write_Data;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_gpio  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + BusWidth'(1);
      if (w_wr && (w_sel == SEL_GPIO)) r_gpio <= bus.i_Write_Data;
      // Setting wins over a coincident clear.
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr && (w_sel == SEL_TXSTAT) && bus.i_Write_Data[OVF])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_txstat                    = '0;
    w_txstat[EMPTY]             = w_empty;
    w_txstat[FULL]              = w_full;
    w_txstat[OVF]               = r_ovf;
    w_txstat[CNT_LSB +: CntW]   = w_count;
    w_rdata = '0;
    case (w_sel)
      SEL_RAM:    w_rdata = r_ram[w_ram_idx];
      SEL_GPIO:   w_rdata = r_gpio;
      SEL_CYCLE:  w_rdata = r_cycle;
      SEL_TXSTAT: w_rdata = w_txstat;
      default:    w_rdata = '0;
    endcase
  end

  assign bus.o_Read_Data = w_rdata;
  assign bus.o_GPIO      = r_gpio;
  assign bus.o_Tx_Data   = w_head;
  assign bus.o_Tx_Valid  = ~w_empty;

endmodule

// File: tb/tb_arm_data_mem_responder.sv
// Purpose : directed-vector scoreboard bench for arm_data_mem_responder.
// Latency : stimulus drives 1 time unit after each rising edge; monitor samples on falling edge.
// Backpr. : i_Tx_Ready toggled by stimulus; TX bytes checked whenever valid & ready.
module tb_arm_data_mem_responder;

  localparam logic [31:0] A_GPIO   = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF04;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF08;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_FF0C;

  typedef enum int {K_RD, K_GPIO, K_TXV, K_TXD} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   tb_cyc;
  int   errors;
  int   checks;
  logic fin_req;
  logic fin_done;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];

  arm_data_mem_responder_if bus();

  arm_data_mem_responder #(.BusWidth(32), .RamWords(64), .TxDepth(8)) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endfunction

  // Monitor: consumes this cycle's expectations and every accepted TX byte.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  b;
    while (exp_q.size() > 0 && exp_q[0].cyc == tb_cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RD:    act = bus.o_Read_Data;
        K_GPIO:  act = bus.o_GPIO;
        K_TXV:   act = {31'd0, bus.o_Tx_Valid};
        default: act = {24'd0, bus.o_Tx_Data};
      endcase
      chk(e.name, act, e.val);
    end
    if (bus.o_Tx_Valid && bus.i_Tx_Ready) begin
      if (tx_q.size() == 0) begin
        chk("tx_unexpected_byte", {24'd0, bus.o_Tx_Data}, 32'hFFFF_FFFF);
      end else begin
        b = tx_q.pop_front();
        chk("tx_byte", {24'd0, bus.o_Tx_Data}, {24'd0, b});
      end
    end
    if (fin_req && !fin_done) begin
      chk("tx_bytes_left", tx_q.size(), 0);
      chk("expects_left", exp_q.size(), 0);
      fin_done = 1'b1;
    end
  end

  task automatic expect_(input kind_e k, input string n, input logic [31:0] v);
    exp_t e;
    e.cyc  = tb_cyc;
    e.kind = k;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    bus.i_Data_Address = a;
    bus.i_Mem_Write    = we;
    bus.i_Write_Data   = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] want, input string n);
    drive(a, 1'b0, 32'd0);
    expect_(K_RD, n, want);
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, 1'b1, d);
    step();
  endtask

  task automatic idle();
    drive(32'd0, 1'b0, 32'd0);
    step();
  endtask

  task automatic push_q(input logic [7:0] b);
    tx_q.push_back(b);
    wr(A_TXDATA, {24'd0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    fin_req  = 1'b0;
    fin_done = 1'b0;
    rst      = 1'b1;
    bus.i_Tx_Ready = 1'b0;
    drive(32'd0, 1'b0, 32'd0);
    step();
    step();

    // Reset state
    expect_(K_GPIO, "rst_gpio", 32'd0);
    expect_(K_TXV, "rst_txvalid", 32'd0);
    rd(A_TXSTAT, 32'h0000_0001, "rst_txstat");

    // CYCLE counts from 0 in the first cycle out of reset
    rst = 1'b0;
    rd(A_CYCLE, 32'd0, "cycle0");
    rd(A_CYCLE, 32'd1, "cycle1");
    rd(A_CYCLE, 32'd2, "cycle2");
    rd(A_CYCLE, 32'd3, "cycle3");
    expect_(K_RD, "cycle_during_write", 32'd4);
    wr(A_CYCLE, 32'h0000_1234);
    rd(A_CYCLE, 32'd5, "cycle_write_ignored");

    // RAM write/read, aliasing, byte-offset ignored, same-cycle old value
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byteoff");
    rd(32'h7FFF_FF10, 32'hDEAD_BEEF, "ram_alias_hi");
    expect_(K_RD, "ram_same_cycle_old", 32'hDEAD_BEEF);
    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "ram_new");

    // GPIO and unmapped MMIO
    wr(A_GPIO, 32'h0000_00A5);
    expect_(K_GPIO, "gpio_out", 32'h0000_00A5);
    rd(A_GPIO, 32'h0000_00A5, "gpio_rd");
    wr(32'hFFFF_FF40, 32'h0000_FFFF);
    expect_(K_GPIO, "gpio_unmapped_wr", 32'h0000_00A5);
    rd(32'hFFFF_FF40, 32'd0, "unmapped_rd");
    rd(A_TXDATA, 32'd0, "txdata_rd");

    // CYCLE wrap, preloaded near the top
    force dut.r_cycle = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle;
    rd(A_CYCLE, 32'hFFFF_FFFE, "cycle_fffe");
    rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_ffff");
    rd(A_CYCLE, 32'h0000_0000, "cycle_wrap0");
    rd(A_CYCLE, 32'h0000_0001, "cycle_wrap1");

    // FIFO fill with consumer stalled
    for (int i = 0; i < 8; i++) begin
      if (i == 0) expect_(K_TXV, "txvalid_no_bypass", 32'd0);
      if (i == 1) expect_(K_TXV, "txvalid_after_push", 32'd1);
      push_q(8'(8'h41 + i));
    end
    rd(A_TXSTAT, 32'h0000_0802, "txstat_full");
    wr(A_TXDATA, 32'h0000_0049);
    expect_(K_TXD, "txdata_head_after_ovf", 32'h0000_0041);
    rd(A_TXSTAT, 32'h0000_0806, "txstat_ovf");
    wr(A_TXSTAT, 32'h0000_0003);
    rd(A_TXSTAT, 32'h0000_0806, "txstat_ovf_kept");
    wr(A_TXSTAT, 32'h0000_0007);
    rd(A_TXSTAT, 32'h0000_0802, "txstat_ovf_clr");

    // Drain in order, one per cycle
    bus.i_Tx_Ready = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    expect_(K_TXV, "txvalid_drained", 32'd0);
    rd(A_TXSTAT, 32'h0000_0001, "txstat_drained");
    bus.i_Tx_Ready = 1'b0;

    // Push while full with a simultaneous pop
    for (int i = 0; i < 8; i++) push_q(8'(8'h50 + i));
    bus.i_Tx_Ready = 1'b1;
    push_q(8'h58);
    bus.i_Tx_Ready = 1'b0;
    rd(A_TXSTAT, 32'h0000_0802, "txstat_full_pushpop");
    bus.i_Tx_Ready = 1'b1;
    for (int i = 0; i < 8; i++) idle();
    bus.i_Tx_Ready = 1'b0;
    rd(A_TXSTAT, 32'h0000_0001, "txstat_drained2");

    // Reset mid-operation
    push_q(8'h61);
    push_q(8'h62);
    push_q(8'h63);
    wr(A_GPIO, 32'h0000_005A);
    expect_(K_GPIO, "gpio_before_rst", 32'h0000_005A);
    rd(A_TXSTAT, 32'h0000_0300, "txstat_three");
    rst = 1'b1;
    tx_q.delete();
    wr(A_GPIO, 32'h0000_00FF);
    rst = 1'b0;
    expect_(K_GPIO, "gpio_after_rst", 32'd0);
    expect_(K_TXV, "txvalid_after_rst", 32'd0);
    rd(A_CYCLE, 32'd0, "cycle_after_rst");
    rd(A_TXSTAT, 32'h0000_0001, "txstat_after_rst");

    // RAM store blocked during reset
    wr(32'h0000_0020, 32'h0000_1111);
    rst = 1'b1;
    wr(32'h0000_0020, 32'h0000_AAAA);
    rst = 1'b0;
    rd(32'h0000_0020, 32'h0000_1111, "ram_wr_blocked_rst");

    idle();
    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_done; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
